// File: rtl/mips_mem_pkg.sv
// Shared opcode constants, FSM state type and opcode classifiers for the
// MIPS load/store access unit.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // LWL/LWR are deliberately absent: they are unaligned by definition.
    function automatic logic is_half(input logic [5:0] op);
        return op inside {OP_LH, OP_LHU, OP_SH};
    endfunction

    function automatic logic is_word(input logic [5:0] op);
        return op inside {OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational byte extract / sign-extend / LWL-LWR merge of a captured
// read word. Byte offset b lives in CPU-side bits [31-8b:24-8b].
module load_align
    import mips_mem_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [4:0]  shl;
    logic [4:0]  shr;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] keep_lo;
    logic [31:0] keep_hi;

    // Shifting left by 8b brings the addressed byte/half to the top of the word.
    assign shl     = {offset, 3'b000};
    assign shr     = {~offset, 3'b000};
    assign left    = word << shl;
    assign right   = word >> shr;
    assign keep_lo = ~(32'hFFFF_FFFF << shl);
    assign keep_hi = ~(32'hFFFF_FFFF >> shr);

    always_comb begin
        result = word;
        case (opcode)
            OP_LB:   result = {{24{left[31]}}, left[31:24]};
            OP_LBU:  result = {24'h000000, left[31:24]};
            OP_LH:   result = {{16{left[31]}}, left[31:16]};
            OP_LHU:  result = {16'h0000, left[31:16]};
            OP_LWL:  result = left | (rt_old & keep_lo);
            OP_LWR:  result = right | (rt_old & keep_hi);
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MIPS datapath and an Avalon-MM master port:
// alignment checks, store lane steering and single-beat bus handshakes.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_result,
    output logic        misaligned,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    state_e      state_q, state_d;
    logic [5:0]  op_q;
    logic [31:0] addr_q, rt_q, result_q;
    logic        skip_q, misal_q;

    logic        accept, bad_align, flag_misal, supported;
    logic [31:0] eff_addr, aligned_word;
    logic [3:0]  store_be;

    assign accept     = (state_q == IDLE) && start;
    assign bad_align  = (is_half(opcode) && addr[0]) ||
                        (is_word(opcode) && (addr[1:0] != 2'b00));
    assign flag_misal = (ALIGN_CHECK != 0) && bad_align;
    assign supported  = is_load(opcode) || is_store(opcode);

    always_comb begin
        eff_addr = addr;
        if (ALIGN_CHECK == 0) begin
            if (is_half(opcode)) eff_addr[0] = 1'b0;
            if (is_word(opcode)) eff_addr[1:0] = 2'b00;
        end
    end

    // Rejected accesses spend one quiet cycle in RD so done lands where a real one would.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (flag_misal || !supported || is_load(opcode)) ? RD : WR;
            RD:   if (skip_q || !avm_waitrequest) state_d = DONE;
            WR:   if (!avm_waitrequest) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= 6'd0;
            addr_q   <= 32'd0;
            rt_q     <= 32'd0;
            result_q <= 32'd0;
            skip_q   <= 1'b0;
            misal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= opcode;
                addr_q  <= eff_addr;
                rt_q    <= rt_data;
                skip_q  <= flag_misal || !supported;
                misal_q <= flag_misal;
            end
            if ((state_q == RD) && !skip_q && !avm_waitrequest) result_q <= aligned_word;
        end
    end

    load_align u_load_align (
        .opcode (op_q),
        .offset (addr_q[1:0]),
        .word   (avm_readdata),
        .rt_old (rt_q),
        .result (aligned_word)
    );

    always_comb begin
        store_be      = 4'b1111;
        avm_writedata = rt_q;
        case (op_q)
            OP_SB: begin
                store_be      = 4'b0001 << addr_q[1:0];
                avm_writedata = {4{rt_q[7:0]}};
            end
            OP_SH: begin
                store_be      = addr_q[1] ? 4'b1100 : 4'b0011;
                avm_writedata = {2{rt_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign misaligned     = done && misal_q;
    assign load_result    = result_q;
    assign avm_address    = {addr_q[31:2], 2'b00};
    assign avm_read       = (state_q == RD) && !skip_q;
    assign avm_write      = (state_q == WR);
    assign avm_byteenable = avm_read ? 4'b1111 : (avm_write ? store_be : 4'b0000);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed expectations checked with
// immediate assertions along one linear stimulus sequence.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        busy, done, misaligned, avm_read, avm_write;
    logic [31:0] load_result, avm_address, avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_waitrequest = 1'b0;

    int checks = 0;
    int passed = 0;

    mem_access_unit #(.ALIGN_CHECK(1)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .opcode          (opcode),
        .addr            (addr),
        .rt_data         (rt_data),
        .busy            (busy),
        .done            (done),
        .load_result     (load_result),
        .misaligned      (misaligned),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Presents a request for one clock edge, then drops start.
    task automatic start_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt);
        opcode  = op;
        addr    = a;
        rt_data = rt;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        // Reset values
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        check("rst_load_result", load_result, 32'd0);
        check("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
        check("rst_byteenable", {28'd0, avm_byteenable}, 32'd0);
        check("rst_address", avm_address, 32'd0);
        check("rst_writedata", avm_writedata, 32'd0);
        tick();
        tick();

        // LW 0x104, first start right as reset releases
        reset_n      = 1'b1;
        avm_readdata = 32'hDEAD_BEEF;
        start_op(6'b100011, 32'h0000_0104, 32'd0);
        check("lw_read", {30'd0, avm_read, avm_write}, 32'd2);
        check("lw_address", avm_address, 32'h0000_0104);
        check("lw_be", {28'd0, avm_byteenable}, 32'hF);
        check("lw_done_early", {31'd0, done}, 32'd0);
        check("lw_busy", {31'd0, busy}, 32'd1);
        tick();
        check("lw_done", {31'd0, done}, 32'd1);
        check("lw_result", load_result, 32'hDEAD_BEEF);
        check("lw_mis", {31'd0, misaligned}, 32'd0);
        check("lw_read_after", {31'd0, avm_read}, 32'd0);
        tick();
        check("lw_idle", {31'd0, busy || done}, 32'd0);
        check("lw_held", load_result, 32'hDEAD_BEEF);

        // LB / LBU 0x103
        avm_readdata = 32'h1122_33F4;
        start_op(6'b100000, 32'h0000_0103, 32'd0);
        tick();
        check("lb_result", load_result, 32'hFFFF_FFF4);
        tick();
        start_op(6'b100100, 32'h0000_0103, 32'd0);
        tick();
        check("lbu_result", load_result, 32'h0000_00F4);
        tick();

        // LH 0x102 (low half) and LHU 0x100 (high half)
        avm_readdata = 32'h1234_8765;
        start_op(6'b100001, 32'h0000_0102, 32'd0);
        tick();
        check("lh_result", load_result, 32'hFFFF_8765);
        tick();
        avm_readdata = 32'h8765_1234;
        start_op(6'b100101, 32'h0000_0100, 32'd0);
        tick();
        check("lhu_result", load_result, 32'h0000_8765);
        tick();

        // SH 0x202 with three waitrequest cycles; start held high meanwhile is ignored
        avm_waitrequest = 1'b1;
        start_op(6'b101001, 32'h0000_0202, 32'h0000_ABCD);
        start   = 1'b1;
        opcode  = 6'b101011;
        addr    = 32'h0000_0000;
        rt_data = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            check("sh_write", {30'd0, avm_read, avm_write}, 32'd1);
            check("sh_be", {28'd0, avm_byteenable}, 32'hC);
            check("sh_wdata", avm_writedata, 32'hABCD_ABCD);
            check("sh_address", avm_address, 32'h0000_0200);
            check("sh_not_done", {31'd0, done}, 32'd0);
            if (i == 3) begin
                avm_waitrequest = 1'b0;
                start           = 1'b0;
            end
            tick();
        end
        check("sh_done", {31'd0, done}, 32'd1);
        check("sh_strobe_off", {28'd0, avm_byteenable}, 32'd0);
        tick();

        // SB 0x101
        start_op(6'b101000, 32'h0000_0101, 32'h1234_5678);
        check("sb_be", {28'd0, avm_byteenable}, 32'h2);
        check("sb_wdata", avm_writedata, 32'h7878_7878);
        tick();
        tick();

        // LWL / LWR 0x1
        avm_readdata = 32'h1122_3344;
        start_op(6'b100010, 32'h0000_0001, 32'hAABB_CCDD);
        check("lwl_be", {28'd0, avm_byteenable}, 32'hF);
        tick();
        check("lwl_result", load_result, 32'h2233_44DD);
        tick();
        start_op(6'b100110, 32'h0000_0001, 32'hAABB_CCDD);
        tick();
        check("lwr_result", load_result, 32'hAABB_1122);
        tick();

        // Misaligned LW 0x2: no strobe, flagged at start+2, result untouched
        start_op(6'b100011, 32'h0000_0002, 32'd0);
        check("mis_no_strobe", {30'd0, avm_read, avm_write}, 32'd0);
        check("mis_be", {28'd0, avm_byteenable}, 32'd0);
        check("mis_busy", {31'd0, busy}, 32'd1);
        tick();
        check("mis_done", {31'd0, done}, 32'd1);
        check("mis_flag", {31'd0, misaligned}, 32'd1);
        check("mis_result", load_result, 32'hAABB_1122);
        tick();
        check("mis_flag_clear", {31'd0, misaligned}, 32'd0);

        // Misaligned SH 0x203
        start_op(6'b101001, 32'h0000_0203, 32'h0000_1111);
        check("mis_sh_no_write", {31'd0, avm_write}, 32'd0);
        tick();
        check("mis_sh_flag", {31'd0, misaligned}, 32'd1);
        tick();

        // Unsupported opcode: done without misaligned
        start_op(6'b001000, 32'h0000_0100, 32'd0);
        check("unsup_no_strobe", {30'd0, avm_read, avm_write}, 32'd0);
        tick();
        check("unsup_done", {31'd0, done}, 32'd1);
        check("unsup_flag", {31'd0, misaligned}, 32'd0);
        check("unsup_result", load_result, 32'hAABB_1122);
        tick();

        // Reset during a stalled RD drops strobes without a clock edge
        avm_waitrequest = 1'b1;
        start_op(6'b100011, 32'h0000_0400, 32'd0);
        check("mid_read", {31'd0, avm_read}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_read", {31'd0, avm_read}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_result", load_result, 32'd0);
        tick();
        reset_n         = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'hDEAD_BEEF;
        start_op(6'b100011, 32'h0000_0104, 32'd0);
        check("post_rst_read", {31'd0, avm_read}, 32'd1);
        tick();
        check("post_rst_done", {31'd0, done}, 32'd1);
        check("post_rst_result", load_result, 32'hDEAD_BEEF);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
